mmio_uart_tx: RTL and testbench



---
 rtl/cpu_pkg.sv | 27 ++
 rtl/uart_tx_fifo.sv | 41 ++++
 rtl/mmio_uart_tx.sv | 131 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and types for the memory-mapped UART transmitter.
package cpu_pkg;

  localparam logic [31:0] TX_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] STAT_ADDR = 32'hFFFF_0004;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_FULL  = 2;
  localparam int unsigned STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Field order matches the STAT_* bit positions (ovf is the MSB).
  typedef struct packed {
    logic ovf;
    logic full;
    logic empty;
    logic busy;
  } uart_stat_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide TX FIFO with extra-MSB pointers for full/empty detection.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Full/empty come from the pre-edge pointers, so a push while full is dropped even with a pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store-bus decode, status read port and serializer.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_0000,
  parameter logic [31:0] STAT_ADDR    = 32'hFFFF_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  input  logic [31:0] r_addr,
  output logic [31:0] r_data,
  output logic        txd,
  output logic        busy
);

  import cpu_pkg::*;

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_e  state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0] shift, shift_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic       ovf;
  logic       txd_c;
  logic       tick;
  logic       push_req, clr_req, stat_hit;
  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  uart_stat_t stat;
  logic       unused_bits;

  assign push_req = we && (w_addr[31:2] == TX_ADDR[31:2]);
  assign clr_req  = we && (w_addr[31:2] == STAT_ADDR[31:2]) && w_data[0];
  assign stat_hit = (r_addr[31:2] == STAT_ADDR[31:2]);
  assign tick     = (cnt == '0);
  assign stat     = '{ovf: ovf, full: fifo_full, empty: fifo_empty, busy: busy};
  assign unused_bits = &{1'b0, w_data[31:8], w_addr[1:0], r_addr[1:0]};

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_req),
    .pop  (fifo_pop),
    .din  (w_data[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Serializer next-state; txd_c is the line level for the current state, registered below.
  always_comb begin
    state_d   = state;
    cnt_d     = tick ? cnt : cnt - CW'(1);
    shift_d   = shift;
    bit_idx_d = bit_idx;
    fifo_pop  = 1'b0;
    txd_c     = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = CNT_MAX;
          state_d  = START;
        end
      end
      START: begin
        txd_c = 1'b0;
        if (tick) begin
          bit_idx_d = 3'd0;
          cnt_d     = CNT_MAX;
          state_d   = DATA;
        end
      end
      DATA: begin
        txd_c = shift[0];
        if (tick) begin
          shift_d   = {1'b0, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          cnt_d     = CNT_MAX;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = CNT_MAX;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
      ovf     <= 1'b0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      r_data  <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      shift   <= shift_d;
      bit_idx <= bit_idx_d;
      txd     <= txd_c;
      busy    <= (state != IDLE) || !fifo_empty;
      // A dropped push in the same cycle as a clear leaves overflow set.
      if (push_req && fifo_full) ovf <= 1'b1;
      else if (clr_req)          ovf <= 1'b0;
      r_data  <= stat_hit ? {28'd0, stat} : 32'd0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_mmio_uart_tx;
  import cpu_pkg::*;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic [31:0] r_addr = '0;
  logic [31:0] r_data;
  logic        txd;
  logic        busy;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .w_addr(w_addr),
    .w_data(w_data),
    .r_addr(r_addr),
    .r_data(r_data),
    .txd   (txd),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we     = 1'b1;
    w_addr = a;
    w_data = d;
    step();
    we     = 1'b0;
    w_addr = '0;
    w_data = '0;
  endtask

  // Cycle-exact frame check starting on the first low cycle of txd.
  task automatic expect_frame(input string tag, input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      check(tag, 32'(txd), 32'(bits[i / CPB]));
      step();
    end
  endtask

  // Wait (bounded) for a start bit, then sample mid-bit; returns mid-stop bit.
  task automatic recv(input string tag, input logic [7:0] exp);
    int         w;
    logic [7:0] got;
    w   = 0;
    got = '0;
    while (txd !== 1'b0 && w < 200) begin
      step();
      w++;
    end
    check({tag, "_found"}, 32'(w < 200), 32'd1);
    step(CPB / 2);
    check({tag, "_start"}, 32'(txd), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(CPB);
      got[k] = txd;
    end
    step(CPB);
    check({tag, "_stop"}, 32'(txd), 32'd1);
    check({tag, "_byte"}, 32'(got), 32'(exp));
  endtask

  initial begin
    int lows;

    step(3);
    rst = 1'b1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", r_data, 32'd0);

    // Status read latency and unmapped read
    r_addr = 32'h0000_0010;
    step();
    check("rd_unmapped", r_data, 32'd0);
    r_addr = STAT_ADDR;
    check("rd_not_comb", r_data, 32'd0);
    step();
    check("rd_stat_idle", r_data, 32'h2);
    r_addr = 32'h0000_0010;
    step();
    check("rd_unmapped2", r_data, 32'd0);
    r_addr = '0;

    // Single frame 0x55
    store(TX_ADDR, 32'h55);
    check("t1_txd_p0", 32'(txd), 32'd1);
    step();
    check("t1_txd_p1", 32'(txd), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    expect_frame("t1_frame", 8'h55);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_txd_idle", 32'(txd), 32'd1);

    // Back-to-back frames, no idle gap
    store(TX_ADDR, 32'h01);
    store(TX_ADDR, 32'h80);
    step();
    expect_frame("t2_frame_a", 8'h01);
    expect_frame("t2_frame_b", 8'h80);
    check("t2_busy_end", 32'(busy), 32'd0);

    // Six writes during START: one in shifter, four queued, one dropped
    store(TX_ADDR, 32'h11);
    store(TX_ADDR, 32'h22);
    store(TX_ADDR, 32'h33);
    store(TX_ADDR, 32'h44);
    store(TX_ADDR, 32'h55);
    store(TX_ADDR, 32'h66);
    r_addr = STAT_ADDR;
    step();
    check("t3_stat_ovf", r_data, 32'hD);
    store(STAT_ADDR, 32'h1);
    step();
    check("t3_stat_clr", r_data, 32'h5);
    // Push lands on the STOP->START pop edge 41 cycles after the first push
    step(32);
    store(TX_ADDR, 32'h77);
    step();
    check("t3_stat_drop", r_data, 32'h9);
    r_addr = '0;
    recv("t3_rx22", 8'h22);
    recv("t3_rx33", 8'h33);
    recv("t3_rx44", 8'h44);
    recv("t3_rx55", 8'h55);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (txd == 1'b0) lows++;
    end
    check("t3_no_extra_frame", 32'(lows), 32'd0);
    check("t3_busy_end", 32'(busy), 32'd0);

    // Reset during data bit 3 of 0xF0 (bit 3 is 0)
    store(TX_ADDR, 32'hF0);
    step(18);
    check("t4_bit3", 32'(txd), 32'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("t4_rst_txd", 32'(txd), 32'd1);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_rdata", r_data, 32'd0);
    r_addr = STAT_ADDR;
    step();
    check("t4_stat_empty", r_data, 32'h2);
    r_addr = '0;
    store(TX_ADDR, 32'hA5);
    recv("t4_rxA5", 8'hA5);
    step(CPB);
    check("t4_busy_end", 32'(busy), 32'd0);
    check("t4_txd_idle", 32'(txd), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

endmodule
